pixel_write_buffer: RTL

- Receiving end of the pixel-plot interface driven by the sprite drawers: each `plot` strobe carries `xCoord`/`yCoord`/`color`.
- Queues accepted pixels in a small FIFO, converts (x,y) to a linear 320x240 framebuffer address and writes to the video RAM port through a valid/ready handshake.
- Also performs a full-screen clear sweep on request.
- Sits between the drawers (spriteFSM and peers) and the VGA framebuffer memory.

---
 rtl/pixel_write_buffer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
//   Receives pixel plots from the sprite drawers and queues them in a small FIFO.
//   Each pixel's (x,y) becomes a linear 320x240 framebuffer address, and the
//   pixel is written to video RAM through a valid/ready handshake. On request,
//   the block also sweeps the whole screen with CLEAR_COLOR.
//
// Ports
//   clock, reset          : system clock (rising edge), async active-high reset
//   plot/xCoord/yCoord/color : pixel strobe and payload, one pixel per high cycle
//   clear_req             : single-cycle full-screen clear request
//   mem_addr/mem_data     : framebuffer write address (y*320+x) and colour
//   mem_we / mem_ready    : write valid / memory accepts this cycle
//   fifo_full             : FIFO holds DEPTH entries
//   overflow              : sticky, an in-range plot was dropped
//   busy                  : sweeping, FIFO non-empty or a write outstanding
//   clear_done            : one-cycle pulse at the end of a sweep
module pixel_write_buffer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned X_MAX       = 320,
    parameter int unsigned Y_MAX       = 240,
    parameter logic [2:0]  CLEAR_COLOR = 3'b111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        plot,
    input  logic [8:0]  xCoord,
    input  logic [7:0]  yCoord,
    input  logic [2:0]  color,
    input  logic        clear_req,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        fifo_full,
    output logic        overflow,
    output logic        busy,
    output logic        clear_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [16:0]   LAST_ADDR = 17'(X_MAX * Y_MAX - 1);

    typedef enum logic [1:0] {
        StRun,
        StClearWait,
        StClear
    } state_e;

    state_e        r_state;
    logic [16:0]   r_addr;
    logic [2:0]    r_data;
    logic          r_we;
    logic          r_clear_done;
    logic          r_overflow;

    // FIFO entry layout: {x[8:0], y[7:0], color[2:0]}
    logic [19:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_in_range;
    logic          w_full;
    logic          w_empty;
    logic          w_flush;
    logic          w_push;
    logic          w_pop;
    logic          w_xfer;
    logic          w_out_free;
    logic [19:0]   w_head;
    logic [8:0]    w_head_x;
    logic [7:0]    w_head_y;
    logic [16:0]   w_head_addr;

    assign w_in_range = (32'(xCoord) < X_MAX) && (32'(yCoord) < Y_MAX);
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // A clear request in RUN discards everything queued, including this cycle's push.
    assign w_flush    = (r_state == StRun) && clear_req;
    assign w_push     = plot && w_in_range && !w_full && !w_flush;
    assign w_xfer     = r_we && mem_ready;
    assign w_out_free = !r_we || mem_ready;
    assign w_pop      = (r_state == StRun) && !clear_req && !w_empty && w_out_free;

    assign w_head      = r_mem[r_rptr];
    assign w_head_x    = w_head[19:11];
    assign w_head_y    = w_head[10:3];
    // y*320 + x as shifts, kept at full 17-bit width
    assign w_head_addr = {1'b0, w_head_y, 8'b0} + {3'b0, w_head_y, 6'b0} + {8'b0, w_head_x};

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Dropped for lack of room, even if a pop frees a slot this same edge
            if (plot && w_in_range && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= {xCoord, yCoord, color};
        end
    end

    // Control FSM and the registered write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= StRun;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            unique case (r_state)
                StRun: begin
                    if (clear_req) begin
                        if (w_out_free) begin
                            r_state <= StClear;
                            r_addr  <= '0;
                            r_data  <= CLEAR_COLOR;
                            r_we    <= 1'b1;
                        end else begin
                            r_state <= StClearWait;
                        end
                    end else if (w_pop) begin
                        r_addr <= w_head_addr;
                        r_data <= w_head[2:0];
                        r_we   <= 1'b1;
                    end else if (w_xfer) begin
                        r_we <= 1'b0;
                    end
                end
                StClearWait: begin
                    // Let the stalled pixel go out, then start the sweep at 0
                    if (w_xfer) begin
                        r_state <= StClear;
                        r_addr  <= '0;
                        r_data  <= CLEAR_COLOR;
                        r_we    <= 1'b1;
                    end
                end
                StClear: begin
                    if (w_xfer) begin
                        if (r_addr == LAST_ADDR) begin
                            r_state      <= StRun;
                            r_we         <= 1'b0;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 17'd1;
                        end
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = r_addr;
    assign mem_data   = r_data;
    assign mem_we     = r_we;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;
    assign clear_done = r_clear_done;
    assign busy       = (r_state != StRun) || !w_empty || r_we;

endmodule
